image_cache_write_arbiter: RTL
==============================

IMAGE_CACHE_WRITE_ARBITER -- requirements
Module: image_cache_write_arbiter

Interface
REQ-001 Parameter: STALL_TIMEOUT, default 64, mid-burst idle cycles before forced grant release (range 2..1023).
REQ-002 Parameter widths: COL_WIDTH and ROW_WIDTH SHALL be taken from pkg_imageCache; word width is fixed at 32.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 rq_valid  input  2  per-requester word valid; index 0 = requester A, index 1 = requester B.
REQ-006 rq_ready  output  2  per-requester word accepted this cycle.
REQ-007 rq_data  input  2x32  per-requester pixel word.
REQ-008 rq_x  input  2xCOL_WIDTH  per-requester column address.
REQ-009 rq_y  input  2xROW_WIDTH  per-requester row address.
REQ-010 rq_last  input  2  marks the final word of the requester's burst (one image row).
REQ-011 icw  output  structs::struct_imageCache_Write  write port to the image cache: we, wdata, waddrX, waddrY.
REQ-012 grant  output  2  one-hot owner of the write port; 00 when idle.
REQ-013 timeout_err  output  2  sticky per-requester flag, set on forced release.

Function
REQ-014 States SHALL be IDLE, OWN_A and OWN_B.
REQ-015 IDLE: if exactly one rq_valid bit is high, the FSM SHALL move to that owner on the next edge.
REQ-016 IDLE: if both rq_valid bits are high, the FSM SHALL grant the requester that is not last_owner; last_owner resets to B, so A wins the first tie.
REQ-017 rq_ready[i] SHALL be combinational: high only when the FSM is in OWN_i and rq_valid[i] is high; no word SHALL be accepted in IDLE.
REQ-018 An accepted word SHALL appear on icw one cycle later, registered, with icw.we=1 for exactly that cycle.
REQ-019 On that cycle icw.wdata, icw.waddrX and icw.waddrY SHALL equal rq_data, rq_x and rq_y at acceptance.
REQ-020 Throughput: one word per cycle while the owner holds rq_valid high.
REQ-021 Ownership SHALL be locked until a word with rq_last=1 is accepted; no interleaving of requesters within a burst.
REQ-022 On accepting a last word, last_owner SHALL update and the FSM SHALL apply the arbitration rules of REQ-015/REQ-016 in the same edge.
REQ-023 REQ-022 means the FSM moves directly to the other owner if that owner is valid, or back to the same owner if only it is valid, with no idle bubble.
REQ-024 A stall counter SHALL clear on every accepted word and increment each owned cycle with rq_valid[owner] low.
REQ-025 When the stall counter reaches STALL_TIMEOUT, timeout_err[owner] SHALL set, last_owner SHALL update and the FSM SHALL go to IDLE.
REQ-026 Words already written before a forced release SHALL NOT be retracted.
REQ-027 When in IDLE, icw.we SHALL be 0.
REQ-028 icw data and address fields SHALL hold their last values when icw.we is 0.
REQ-029 Single-word bursts (rq_valid and rq_last high on the first accepted word) SHALL take exactly 1 owned cycle.
REQ-030 The block SHALL NOT check address ranges; rq_x and rq_y values SHALL pass through unchanged.
REQ-031 timeout_err bits SHALL clear only on reset.

Reset
REQ-032 On resetn low, these SHALL take effect immediately, irrespective of clk: state=IDLE, grant=00, rq_ready=00, icw.we=0, icw.wdata/waddrX/waddrY=0, stall counter=0, last_owner=B, timeout_err=00.
REQ-033 If reset is asserted mid-burst, the burst SHALL be abandoned.
REQ-034 The pipelined icw.we SHALL be cleared on reset; no write SHALL occur on the first edge after resetn deasserts.

Verification
REQ-035 Tie: after reset, drive rq_valid=11 with A bursting 4 words then B bursting 4 words. Required: grant=01 for 4 words, then grant=10 with zero gap cycles; 8 icw.we pulses in A-then-B order.
REQ-036 Lock: A holds a burst with valid gaps while B stays valid. Required: no B write until A's rq_last word is accepted.
REQ-037 Timeout (STALL_TIMEOUT=8): A accepts 2 words, then drops valid. Required: after 8 stall cycles timeout_err=01, FSM returns to IDLE, B is granted next, and 2 A writes are present on icw.
REQ-038 Latency/data: A sends x=5, y=3, data=0xDEADBEEF. Required: one cycle later icw.we=1, waddrX=5, waddrY=3, wdata=0xDEADBEEF.
REQ-039 Reset mid-burst: resetn pulled low between edges. Required: outputs reach reset values before the next edge, and the first write after release follows the tie rule.
REQ-040 Single-word alternation: A and B both continuously valid with rq_last=1. Required: grant alternates every cycle and icw.we stays high continuously.

Source files
------------

// File: rtl/pkg_imageCache.sv
// Image cache geometry shared by every block that addresses the cache.
package pkg_imageCache;

    parameter int unsigned COL_WIDTH = 10;
    parameter int unsigned ROW_WIDTH = 9;

endpackage

// File: rtl/structs.sv
// Port bundles used between image-cache clients and the cache itself.
package structs;

    typedef struct packed {
        logic                                 we;
        logic [31:0]                          wdata;
        logic [pkg_imageCache::COL_WIDTH-1:0] waddrX;
        logic [pkg_imageCache::ROW_WIDTH-1:0] waddrY;
    } struct_imageCache_Write;

endpackage

// File: rtl/image_cache_write_arbiter.sv
// Two-requester burst arbiter for the image cache write port.
// A burst (one image row) owns the port until its last word is accepted or
// the owner stalls for STALL_TIMEOUT cycles; ties alternate via last owner.
module image_cache_write_arbiter #(
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic                                       clk,
    input  logic                                       resetn,
    input  logic [1:0]                                 rq_valid,
    output logic [1:0]                                 rq_ready,
    input  logic [1:0][31:0]                           rq_data,
    input  logic [1:0][pkg_imageCache::COL_WIDTH-1:0]  rq_x,
    input  logic [1:0][pkg_imageCache::ROW_WIDTH-1:0]  rq_y,
    input  logic [1:0]                                 rq_last,
    output structs::struct_imageCache_Write            icw,
    output logic [1:0]                                 grant,
    output logic [1:0]                                 timeout_err
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN_A,
        OWN_B
    } state_t;

    state_t                          state_q, state_d;
    logic                            last_owner_q, last_owner_d;   // 1 = B
    logic [CNT_W-1:0]                stall_q, stall_d;
    logic [1:0]                      terr_q, terr_d;
    structs::struct_imageCache_Write icw_q, icw_d;

    logic own;
    logic accept;

    // Pick the next owner from the valid pattern; a tie goes to whoever
    // did not own the port last.
    function automatic state_t arbitrate(input logic [1:0] vld, input logic lo_b);
        state_t s;
        s = IDLE;
        if (vld == 2'b01) begin
            s = OWN_A;
        end else if (vld == 2'b10) begin
            s = OWN_B;
        end else if (vld == 2'b11) begin
            s = lo_b ? OWN_A : OWN_B;
        end
        return s;
    endfunction

    // Ownership decode, handshake, next-state and write-port capture.
    always_comb begin
        grant        = '0;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        stall_d      = stall_q;
        terr_d       = terr_q;

        case (state_q)
            OWN_A:   grant = 2'b01;
            OWN_B:   grant = 2'b10;
            default: grant = 2'b00;
        endcase

        rq_ready = grant & rq_valid;
        accept   = |rq_ready;
        own      = (state_q == OWN_B);

        icw_d    = icw_q;
        icw_d.we = accept;
        if (accept) begin
            icw_d.wdata  = rq_data[own];
            icw_d.waddrX = rq_x[own];
            icw_d.waddrY = rq_y[own];
        end

        case (state_q)
            IDLE: begin
                stall_d = '0;
                state_d = arbitrate(rq_valid, last_owner_q);
            end
            default: begin
                // While owned, "not accepted" can only mean the owner is not valid.
                if (accept) begin
                    stall_d = '0;
                    if (rq_last[own]) begin
                        last_owner_d = own;
                        state_d      = arbitrate(rq_valid, own);
                    end
                end else if (stall_q == STALL_LAST) begin
                    terr_d[own]  = 1'b1;
                    last_owner_d = own;
                    stall_d      = '0;
                    state_d      = IDLE;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
        endcase
    end

    // State, counter, sticky flags and registered write port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            stall_q      <= '0;
            terr_q       <= '0;
            icw_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            stall_q      <= stall_d;
            terr_q       <= terr_d;
            icw_q        <= icw_d;
        end
    end

    assign icw         = icw_q;
    assign timeout_err = terr_q;

endmodule
